// File: rtl/phy_tx_lane_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : phy_tx_lane_arbiter_if
//  Purpose  : Bundles the four lane source inputs, the per-lane pop strobes,
//             the downstream slot handshake and the registered byte output
//             of the PHY transmit lane arbiter.
//  Ports    : none (signal bundle only)
//             in_valid[3:0], in_data0..3[7:0], tx_ready   : source side
//             in_pop[3:0], data_out[7:0], valid_out,
//             active_out, grant_id[1:0]                   : arbiter side
//  Modports : master - lane sources / downstream stage (drives the inputs)
//             slave  - the arbiter
//  Revision : 1.0 - initial release
// ============================================================================
interface phy_tx_lane_arbiter_if;
    logic [3:0] in_valid;
    logic [7:0] in_data0;
    logic [7:0] in_data1;
    logic [7:0] in_data2;
    logic [7:0] in_data3;
    logic [3:0] in_pop;
    logic       tx_ready;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active_out;
    logic [1:0] grant_id;

    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, tx_ready,
        input  in_pop, data_out, valid_out, active_out, grant_id
    );

    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, tx_ready,
        output in_pop, data_out, valid_out, active_out, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/phy_tx_lane_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : phy_tx_lane_arbiter
//  Purpose  : Round-robin scheduler sharing the PHY transmit byte path among
//             four lane sources. After reset it sends NUM_COM COM symbols,
//             raises active_out, then grants one lane per byte slot (bursts
//             of up to MAX_BURST bytes) or fills the slot with IDL.
//  Ports    : clk    in  byte-rate clock, rising edge
//             reset  in  synchronous active-high reset
//             bus    slave modport: in_valid/in_data0..3/tx_ready in,
//                    in_pop (comb) and registered data_out/valid_out/
//                    active_out/grant_id out
//  Revision : 1.0 - initial release
// ============================================================================
module phy_tx_lane_arbiter #(
    parameter int         NUM_COM   = 4,
    parameter int         MAX_BURST = 2,
    parameter logic [7:0] COM_SYM   = 8'hBC,
    parameter logic [7:0] IDL_SYM   = 8'h7C
) (
    input  wire logic             clk,
    input  wire logic             reset,
    phy_tx_lane_arbiter_if.slave  bus
);

    localparam int CW = $clog2(NUM_COM + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_ARB  = 1'b1;

    logic [0:0]    state_q,     state_d;
    logic [CW-1:0] com_cnt_q,   com_cnt_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic [1:0]    rr_ptr_q,    rr_ptr_d;
    logic [7:0]    data_out_q,  data_out_d;
    logic          valid_out_q, valid_out_d;
    logic          active_q,    active_d;
    logic [1:0]    grant_q,     grant_d;

    logic [7:0]    lane_data [4];
    logic          owner_live;
    logic          keep_owner;
    logic [1:0]    scan_base;
    logic [1:0]    scan_idx;
    logic          found;
    logic [1:0]    pick;
    logic          sel_valid;
    logic [1:0]    sel_lane;
    logic          last_com;

    assign lane_data[0] = bus.in_data0;
    assign lane_data[1] = bus.in_data1;
    assign lane_data[2] = bus.in_data2;
    assign lane_data[3] = bus.in_data3;

    // A nonzero burst count means grant_q names a lane that currently owns
    // the path; an idle slot clears the count and with it the ownership.
    assign owner_live = (burst_cnt_q != '0);
    assign keep_owner = owner_live && bus.in_valid[grant_q]
                        && (burst_cnt_q < BW'(MAX_BURST));
    // Ending a burst moves the pointer past the old owner and the scan uses
    // the moved pointer in the same cycle, so no bubble slot appears.
    assign scan_base  = (owner_live && !keep_owner) ? grant_q + 2'd1 : rr_ptr_q;
    assign last_com   = (com_cnt_q == CW'(NUM_COM - 1));

    always_comb begin
        found    = 1'b0;
        pick     = 2'd0;
        scan_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            scan_idx = scan_base + 2'(i);
            if (!found && bus.in_valid[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    assign sel_valid = keep_owner || found;
    assign sel_lane  = keep_owner ? grant_q : pick;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (bus.tx_ready && (state_q == ST_SYNC) && last_com) begin
            state_d = ST_ARB;
        end
    end

    // FSM: outputs (pop strobe is combinational and suppressed during reset)
    always_comb begin
        bus.in_pop = 4'b0000;
        if (!reset && bus.tx_ready && (state_q == ST_ARB) && sel_valid) begin
            bus.in_pop = 4'b0001 << sel_lane;
        end
    end

    // Datapath next values; everything holds while tx_ready is low.
    always_comb begin
        com_cnt_d   = com_cnt_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        active_d    = active_q;
        grant_d     = grant_q;
        if (bus.tx_ready) begin
            if (state_q == ST_SYNC) begin
                data_out_d  = COM_SYM;
                valid_out_d = 1'b0;
                com_cnt_d   = com_cnt_q + CW'(1);
                if (last_com) begin
                    active_d = 1'b1;
                end
            end else begin
                rr_ptr_d = scan_base;
                if (sel_valid) begin
                    data_out_d  = lane_data[sel_lane];
                    valid_out_d = 1'b1;
                    grant_d     = sel_lane;
                    burst_cnt_d = keep_owner ? burst_cnt_q + BW'(1) : BW'(1);
                end else begin
                    data_out_d  = IDL_SYM;
                    valid_out_d = 1'b0;
                    burst_cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            com_cnt_q   <= '0;
            burst_cnt_q <= '0;
            rr_ptr_q    <= 2'd0;
            data_out_q  <= 8'h00;
            valid_out_q <= 1'b0;
            active_q    <= 1'b0;
            grant_q     <= 2'd0;
        end else begin
            com_cnt_q   <= com_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            active_q    <= active_d;
            grant_q     <= grant_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.active_out = active_q;
    assign bus.grant_id   = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_phy_tx_lane_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phy_tx_lane_arbiter
//  Purpose  : Directed bench for phy_tx_lane_arbiter with a cycle model of
//             the scheduling rules checked every cycle, plus literal checks
//             for training, rotation order, single lane, stall, early drop
//             and mid-burst reset.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_phy_tx_lane_arbiter;

    localparam int         NUM_COM   = 4;
    localparam int         MAX_BURST = 2;
    localparam logic [7:0] COM_SYM   = 8'hBC;
    localparam logic [7:0] IDL_SYM   = 8'h7C;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 0;
    int   seq = 0;

    phy_tx_lane_arbiter_if bus ();

    phy_tx_lane_arbiter #(
        .NUM_COM   (NUM_COM),
        .MAX_BURST (MAX_BURST),
        .COM_SYM   (COM_SYM),
        .IDL_SYM   (IDL_SYM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         m_com, m_owner, m_burst, m_rr, m_grant;
    logic [7:0] m_data;
    bit         m_valid, m_active;

    function automatic logic [7:0] lane_byte(input int k);
        case (k)
            0:       return bus.in_data0;
            1:       return bus.in_data1;
            2:       return bus.in_data2;
            default: return bus.in_data3;
        endcase
    endfunction

    // Selection rule: keep the owner while it requests and has budget,
    // otherwise scan from the (possibly advanced) pointer with wraparound.
    function automatic void model_pick(input logic [3:0] v, output int lane,
                                       output int rr_n, output bit keep);
        lane = -1;
        rr_n = m_rr;
        keep = (m_owner >= 0) && v[m_owner] && (m_burst < MAX_BURST);
        if (keep) begin
            lane = m_owner;
        end else begin
            if (m_owner >= 0) rr_n = (m_owner + 1) % 4;
            for (int i = 0; i < 4; i++)
                if (lane < 0 && v[(rr_n + i) % 4]) lane = (rr_n + i) % 4;
        end
    endfunction

    function automatic logic [3:0] model_pop();
        int lane, rr_n;
        bit keep;
        if (reset || !bus.tx_ready || !m_active) return 4'b0000;
        model_pick(bus.in_valid, lane, rr_n, keep);
        if (lane < 0) return 4'b0000;
        return 4'(1 << lane);
    endfunction

    task automatic model_reset();
        m_com = 0; m_owner = -1; m_burst = 0; m_rr = 0; m_grant = 0;
        m_data = 8'h00; m_valid = 0; m_active = 0;
    endtask

    task automatic model_step();
        int lane, rr_n;
        bit keep;
        if (reset) begin
            model_reset();
        end else if (bus.tx_ready) begin
            if (!m_active) begin
                m_data = COM_SYM; m_valid = 0; m_com++;
                if (m_com == NUM_COM) m_active = 1;
            end else begin
                model_pick(bus.in_valid, lane, rr_n, keep);
                m_rr = rr_n;
                if (lane >= 0) begin
                    m_burst = keep ? m_burst + 1 : 1;
                    m_owner = lane;
                    m_grant = lane;
                    m_data  = lane_byte(lane);
                    m_valid = 1;
                end else begin
                    m_data = IDL_SYM; m_valid = 0; m_burst = 0; m_owner = -1;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("model_pop",    32'(bus.in_pop),     32'(model_pop()));
                chk("model_data",   32'(bus.data_out),   32'(m_data));
                chk("model_valid",  32'(bus.valid_out),  32'(m_valid));
                chk("model_active", 32'(bus.active_out), 32'(m_active));
                chk("model_grant",  32'(bus.grant_id),   32'(m_grant[1:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        seq++;
        bus.in_data0 = 8'(8'h10 + seq);
        bus.in_data1 = 8'(8'h20 + seq);
        bus.in_data2 = 8'(8'h30 + seq);
        bus.in_data3 = 8'(8'h40 + seq);
    endtask

    int exp2 [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    initial begin
        reset        = 1'b1;
        bus.tx_ready = 1'b0;
        bus.in_valid = 4'b0000;
        bus.in_data0 = 8'h10;
        bus.in_data1 = 8'h20;
        bus.in_data2 = 8'h30;
        bus.in_data3 = 8'h40;

        // 1: reset, COM training, idle fill
        step();
        chk_en = 1;
        @(negedge clk);
        chk("rst_data",   32'(bus.data_out),   32'h00);
        chk("rst_valid",  32'(bus.valid_out),  32'h0);
        chk("rst_active", 32'(bus.active_out), 32'h0);
        chk("rst_grant",  32'(bus.grant_id),   32'h0);
        chk("rst_pop",    32'(bus.in_pop),     32'h0);
        step();
        reset        = 1'b0;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk("com_data",   32'(bus.data_out),   32'hBC);
            chk("com_valid",  32'(bus.valid_out),  32'h0);
            chk("com_active", 32'(bus.active_out), (i == 3) ? 32'h1 : 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            chk("idle_data",  32'(bus.data_out),  32'h7C);
            chk("idle_valid", 32'(bus.valid_out), 32'h0);
        end

        // 2: all lanes requesting -> paired rotation
        bus.in_valid = 4'hF;
        for (int j = 0; j < 9; j++) begin
            step();
            @(negedge clk);
            chk("rot_grant", 32'(bus.grant_id),  32'(exp2[j]));
            chk("rot_valid", 32'(bus.valid_out), 32'h1);
        end

        // 3: only lane 2 requests -> continuous lane 2
        bus.in_valid = 4'b0100;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("solo_pop", 32'(bus.in_pop), 32'h4);
            step();
            @(negedge clk);
            chk("solo_grant", 32'(bus.grant_id),  32'h2);
            chk("solo_valid", 32'(bus.valid_out), 32'h1);
        end

        // 4: stall in the middle of a lane 1 burst
        bus.in_valid = 4'b0010;
        step();
        @(negedge clk);
        chk("stall_start", 32'(bus.grant_id), 32'h1);
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("stall_pop",   32'(bus.in_pop),    32'h0);
            chk("stall_grant", 32'(bus.grant_id),  32'h1);
            chk("stall_valid", 32'(bus.valid_out), 32'h1);
        end
        bus.tx_ready = 1'b1;
        step();
        @(negedge clk);
        chk("resume_grant", 32'(bus.grant_id),  32'h1);
        chk("resume_valid", 32'(bus.valid_out), 32'h1);
        bus.in_valid = 4'b0000;
        step();
        @(negedge clk);
        chk("drain_data", 32'(bus.data_out), 32'h7C);

        // 5: lane 0 drops after one byte -> lane 1 next, no idle slot
        bus.in_valid = 4'b0011;
        step();
        @(negedge clk);
        chk("drop_first", 32'(bus.grant_id), 32'h0);
        bus.in_valid = 4'b0010;
        step();
        @(negedge clk);
        chk("drop_next_grant", 32'(bus.grant_id),  32'h1);
        chk("drop_next_valid", 32'(bus.valid_out), 32'h1);

        // 6: reset during a lane 3 burst
        bus.in_valid = 4'b1000;
        step();
        @(negedge clk);
        chk("l3_grant", 32'(bus.grant_id), 32'h3);
        reset = 1'b1;
        #1;
        chk("rst_mid_pop", 32'(bus.in_pop), 32'h0);
        step();
        @(negedge clk);
        chk("rst_mid_valid",  32'(bus.valid_out),  32'h0);
        chk("rst_mid_active", 32'(bus.active_out), 32'h0);
        chk("rst_mid_data",   32'(bus.data_out),   32'h00);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("resync_pop", 32'(bus.in_pop), 32'h0);
            step();
            @(negedge clk);
            chk("resync_data",  32'(bus.data_out),  32'hBC);
            chk("resync_valid", 32'(bus.valid_out), 32'h0);
        end
        chk("resync_active", 32'(bus.active_out), 32'h1);
        step();
        @(negedge clk);
        chk("resync_l3_grant", 32'(bus.grant_id),  32'h3);
        chk("resync_l3_valid", 32'(bus.valid_out), 32'h1);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
